// File: rtl/and_gate_rr_arbiter.sv
// Round-robin arbiter and sequencer for one shared AND gate.
// Requesters are granted one at a time. The operands of the granted
// requester are registered onto the gate inputs. The gate result is
// returned with a one-cycle response pulse, compared against the
// expected AND, and the completed transaction is counted.
module and_gate_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  a_in,
    input  logic [NREQ-1:0]  b_in,
    output logic [NREQ-1:0]  gnt,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic [NREQ-1:0]  rsp_valid,
    output logic             rsp_y,
    output logic             busy,
    output logic             mismatch_err,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned IDX_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_win;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_rsp_valid;
    logic             r_gate_a;
    logic             r_gate_b;
    logic             r_rsp_y;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_txn_cnt;

    logic             w_found;
    logic [PTR_W-1:0] w_win;
    logic [IDX_W-1:0] w_idx;
    logic [NREQ-1:0]  w_win_oh;

    // Find the first requester at or after r_ptr, wrapping at NREQ.
    // The index is one bit wider than the pointer so ptr+i never overflows before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + IDX_W'(i);
            if (w_idx >= IDX_W'(NREQ)) begin
                w_idx = w_idx - IDX_W'(NREQ);
            end
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    // One-hot encode the current winner for the grant.
    always_comb begin
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    // Transaction FSM: grant and capture operands, sample the gate, then retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_gate_a    <= 1'b0;
            r_gate_b    <= 1'b0;
            r_rsp_y     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_txn_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win_oh;
                        r_win    <= w_win;
                        r_gate_a <= a_in[w_win];
                        r_gate_b <= b_in[w_win];
                        r_state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_rsp_y     <= gate_y;
                    r_rsp_valid <= r_gnt;
                    if (gate_y != (r_gate_a & r_gate_b)) begin
                        r_mismatch <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_gnt       <= '0;
                    r_rsp_valid <= '0;
                    r_gate_a    <= 1'b0;
                    r_gate_b    <= 1'b0;
                    r_txn_cnt   <= r_txn_cnt + 1'b1;
                    if (r_win == PTR_W'(NREQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy flag is decoded directly from the state.
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    assign gnt          = r_gnt;
    assign gate_a       = r_gate_a;
    assign gate_b       = r_gate_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_y        = r_rsp_y;
    assign mismatch_err = r_mismatch;
    assign txn_cnt      = r_txn_cnt;

endmodule

// File: tb/tb_and_gate_rr_arbiter.sv
// Directed self-checking bench for and_gate_rr_arbiter (NREQ=4, CNT_W=8).
// The shared gate is modelled as a plain AND, with an override that forces Y low.
module tb_and_gate_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] gnt;
    logic       gate_a;
    logic       gate_b;
    logic       gate_y;
    logic [3:0] rsp_valid;
    logic       rsp_y;
    logic       busy;
    logic       mismatch_err;
    logic [7:0] txn_cnt;
    logic       inj;

    int n_pass  = 0;
    int n_total = 0;

    assign gate_y = inj ? 1'b0 : (gate_a & gate_b);

    and_gate_rr_arbiter #(.NREQ(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .gate_a       (gate_a),
        .gate_b       (gate_b),
        .gate_y       (gate_y),
        .rsp_valid    (rsp_valid),
        .rsp_y        (rsp_y),
        .busy         (busy),
        .mismatch_err (mismatch_err),
        .txn_cnt      (txn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b1; req = '0; a_in = '0; b_in = '0; inj = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b exp 0000", gnt); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); else n_pass++;
        n_total++; if ({gate_a, gate_b, rsp_y, busy, mismatch_err} !== 5'b00000)
            $display("FAIL reset_flags: got %b exp 00000", {gate_a, gate_b, rsp_y, busy, mismatch_err}); else n_pass++;
        n_total++; if (txn_cnt !== 8'd0) $display("FAIL reset_txn_cnt: got %0d exp 0", txn_cnt); else n_pass++;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 4'b0001; a_in = 4'b0001; b_in = 4'b0001;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b exp 0001", gnt); else n_pass++;
        n_total++; if ({gate_a, gate_b, busy} !== 3'b111) $display("FAIL single_drive: got %b exp 111", {gate_a, gate_b, busy}); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_early_rsp: got %b exp 0000", rsp_valid); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b exp 0001", rsp_valid); else n_pass++;
        n_total++; if (rsp_y !== 1'b1) $display("FAIL single_rsp_y: got %b exp 1", rsp_y); else n_pass++;
        n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt_hold: got %b exp 0001", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_end: got %b exp 0000", rsp_valid); else n_pass++;
        n_total++; if ({gnt, busy} !== 5'b00000) $display("FAIL single_idle: got %b exp 00000", {gnt, busy}); else n_pass++;
        n_total++; if (txn_cnt !== 8'd1) $display("FAIL single_txn_cnt: got %0d exp 1", txn_cnt); else n_pass++;
    endtask

    task automatic test_truth_table();
        logic [1:0] pat;
        logic       exp_y;
        for (int p = 0; p < 4; p++) begin
            pat   = 2'(p);
            exp_y = (p == 3);
            @(negedge clk);
            req = 4'b0100; a_in = {1'b0, pat[1], 2'b00}; b_in = {1'b0, pat[0], 2'b00};
            @(posedge clk); #1;
            n_total++; if (gnt !== 4'b0100) $display("FAIL tt_gnt[%0d]: got %b exp 0100", p, gnt); else n_pass++;
            @(negedge clk);
            req = 4'b0000;
            @(posedge clk); #1;
            n_total++; if (rsp_valid !== 4'b0100) $display("FAIL tt_rsp_valid[%0d]: got %b exp 0100", p, rsp_valid); else n_pass++;
            n_total++; if (rsp_y !== exp_y) $display("FAIL tt_rsp_y[%0d]: got %b exp %b", p, rsp_y, exp_y); else n_pass++;
            @(posedge clk); #1;
        end
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL tt_mismatch: got %b exp 0", mismatch_err); else n_pass++;
        n_total++; if (txn_cnt !== 8'd5) $display("FAIL tt_txn_cnt: got %0d exp 5", txn_cnt); else n_pass++;
    endtask

    task automatic test_late_change();
        @(negedge clk);
        req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL late_gnt: got %b exp 0010", gnt); else n_pass++;
        @(negedge clk);
        a_in = 4'b0000; req = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (gate_a !== 1'b1) $display("FAIL late_gate_a: got %b exp 1", gate_a); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0010) $display("FAIL late_rsp_valid: got %b exp 0010", rsp_valid); else n_pass++;
        n_total++; if (rsp_y !== 1'b1) $display("FAIL late_rsp_y: got %b exp 1", rsp_y); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL late_rsp_end: got %b exp 0000", rsp_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({rsp_valid, gnt} !== 8'h00) $display("FAIL late_no_repeat: got %b exp 00000000", {rsp_valid, gnt}); else n_pass++;
        n_total++; if (txn_cnt !== 8'd6) $display("FAIL late_txn_cnt: got %0d exp 6", txn_cnt); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        logic       exp_y;
        logic [7:0] exp_c;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111; a_in = 4'b1010; b_in = 4'b1110;
        for (int t = 0; t < 256; t++) begin
            exp_g = 4'b0001 << (t % 4);
            exp_y = |(exp_g & 4'b1010);
            @(posedge clk); #1;
            n_total++; if (gnt !== exp_g) $display("FAIL fair_gnt[%0d]: got %b exp %b", t, gnt, exp_g); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (rsp_valid !== exp_g) $display("FAIL fair_rsp_valid[%0d]: got %b exp %b", t, rsp_valid, exp_g); else n_pass++;
            n_total++; if (rsp_y !== exp_y) $display("FAIL fair_rsp_y[%0d]: got %b exp %b", t, rsp_y, exp_y); else n_pass++;
            @(posedge clk); #1;
            exp_c = 8'(t + 1);
            n_total++; if (txn_cnt !== exp_c) $display("FAIL fair_txn_cnt[%0d]: got %0d exp %0d", t, txn_cnt, exp_c); else n_pass++;
            n_total++; if (gnt !== 4'b0000) $display("FAIL fair_idle[%0d]: got %b exp 0000", t, gnt); else n_pass++;
        end
        req = 4'b0000;
        n_total++; if (txn_cnt !== 8'd0) $display("FAIL fair_wrap: got %0d exp 0", txn_cnt); else n_pass++;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL fair_mismatch: got %b exp 0", mismatch_err); else n_pass++;
    endtask

    task automatic test_error_injection();
        @(negedge clk);
        req = 4'b0001; a_in = 4'b0001; b_in = 4'b0001; inj = 1'b1;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL err_gnt: got %b exp 0001", gnt); else n_pass++;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL err_early: got %b exp 0", mismatch_err); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        inj = 1'b0;
        n_total++; if (mismatch_err !== 1'b1) $display("FAIL err_rise: got %b exp 1", mismatch_err); else n_pass++;
        n_total++; if (rsp_y !== 1'b0) $display("FAIL err_rsp_y: got %b exp 0", rsp_y); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL err_gnt2: got %b exp 0010", gnt); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (rsp_y !== 1'b1) $display("FAIL err_rsp_y2: got %b exp 1", rsp_y); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (mismatch_err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", mismatch_err); else n_pass++;
        n_total++; if (txn_cnt !== 8'd2) $display("FAIL err_txn_cnt: got %0d exp 2", txn_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 4'b1000; a_in = 4'b1000; b_in = 4'b1000;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b1000) $display("FAIL rmid_gnt: got %b exp 1000", gnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if ({gnt, rsp_valid} !== 8'h00) $display("FAIL rmid_async: got %b exp 00000000", {gnt, rsp_valid}); else n_pass++;
        n_total++; if ({gate_a, gate_b, busy, mismatch_err} !== 4'b0000)
            $display("FAIL rmid_flags: got %b exp 0000", {gate_a, gate_b, busy, mismatch_err}); else n_pass++;
        n_total++; if (txn_cnt !== 8'd0) $display("FAIL rmid_txn_cnt: got %0d exp 0", txn_cnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rmid_no_rsp: got %b exp 0000", rsp_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; req = 4'b1010; a_in = 4'b0010; b_in = 4'b0010;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL rmid_ptr0: got %b exp 0010", gnt); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 4'b0010) $display("FAIL rmid_rsp: got %b exp 0010", rsp_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (txn_cnt !== 8'd1) $display("FAIL rmid_txn_after: got %0d exp 1", txn_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_truth_table();
        test_late_change();
        test_fairness();
        test_error_injection();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
